diag_pipe_stage: RTL and testbench

Parametrised, handshaked pipeline stage register for the pipelined core. It generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. The block carries a control field and a data field of configurable width. It adds valid/ready flow control, stall, and flush-to-bubble, plus an optional skid entry that lets in_ready be fully registered. One instance sits between every pair of adjacent pipeline stages.

---
 rtl/diag_pipe_stage.sv | 114 +++++++++++
 tb/tb_diag_pipe_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/diag_pipe_stage.sv
// Handshaked pipeline stage register: one head entry drives the outputs.
// An optional skid entry lets in_ready come straight from a flop.
module diag_pipe_stage #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 64*4+5,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
);

   // State bits are {main_v, skid_v}, so the entry valids fall out of the encoding.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_TWO   = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic                main_v, skid_v;
   logic                accept, deliver;

   assign main_v = state_q[1];
   assign skid_v = state_q[0];

   // Without a skid entry, a stalled head frees its slot in the same cycle it delivers.
   assign in_ready  = (SKID != 0) ? !skid_v : (!main_v || out_ready);
   assign accept    = in_valid && in_ready;
   assign deliver   = main_v && out_ready;

   assign out_valid = main_v;
   assign out_ctrl  = main_v ? main_ctrl_q : '0;
   assign out_data  = main_data_q;

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         // Payload stays put; only the valids die, and any same-cycle accept is dropped.
         state_d = ST_EMPTY;
      end else if (SKID != 0) begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
            end
            ST_ONE: begin
               if (deliver && accept) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (deliver) begin
                  state_d = ST_EMPTY;
               end else if (accept) begin
                  state_d     = ST_TWO;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end
            end
            ST_TWO: begin
               if (deliver) begin
                  state_d     = ST_ONE;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end else begin
         if (accept) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
         end else if (deliver) begin
            state_d = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

endmodule

// File: tb/tb_diag_pipe_stage.sv
// Bench for diag_pipe_stage: SKID=1 and SKID=0 instances share stimulus and are
// checked every cycle against FIFO-queue models, plus directed literal checks.
module tb_diag_pipe_stage;
   localparam int CW = 16;
   localparam int DW = 64*4+5;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;

   logic          rdy1, ov1, rdy0, ov0;
   logic [CW-1:0] oc1, oc0;
   logic [DW-1:0] od1, od0;

   int n_chk  = 0;
   int n_pass = 0;
   int dcnt20 = 0;
   bit mon_en = 1'b0;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } item_t;
   item_t q1[$];
   item_t q0[$];

   always #5 clk = ~clk;

   diag_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1)
   );

   diag_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
   endtask

   // Model: a bounded FIFO. Capacity 2 with in_ready = not full (SKID=1);
   // capacity 1 with in_ready = empty or draining (SKID=0).
   always @(posedge clk) begin
      bit acc1, acc0, dlv1, dlv0;
      if (reset) begin
         q1.delete();
         q0.delete();
      end else begin
         acc1 = in_valid && (q1.size() < 2);
         acc0 = in_valid && (q0.size() == 0 || out_ready);
         dlv1 = (q1.size() > 0) && out_ready;
         dlv0 = (q0.size() > 0) && out_ready;
         if (flush) begin
            q1.delete();
            q0.delete();
         end else begin
            if (dlv1) void'(q1.pop_front());
            if (acc1) q1.push_back(item_t'{c: in_ctrl, d: in_data});
            if (dlv0) void'(q0.pop_front());
            if (acc0) q0.push_back(item_t'{c: in_ctrl, d: in_data});
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("u1_out_valid", DW'(ov1), DW'(q1.size() > 0));
         chk("u1_in_ready", DW'(rdy1), DW'(q1.size() < 2));
         chk("u1_out_ctrl", DW'(oc1), (q1.size() > 0) ? DW'(q1[0].c) : '0);
         if (q1.size() > 0) chk("u1_out_data", od1, q1[0].d);
         chk("u0_out_valid", DW'(ov0), DW'(q0.size() > 0));
         chk("u0_in_ready", DW'(rdy0), DW'(q0.size() == 0 || out_ready));
         chk("u0_out_ctrl", DW'(oc0), (q0.size() > 0) ? DW'(q0[0].c) : '0);
         if (q0.size() > 0) chk("u0_out_data", od0, q0[0].d);
      end
      if (ov1 && out_ready && od1 == DW'(20)) dcnt20++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int k);
      in_valid = v;
      in_ctrl  = CW'(k);
      in_data  = DW'(k);
   endtask

   initial begin
      int tag;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = DW'(5);
      step();
      mon_en = 1'b1;
      step();
      chk("rst_out_valid", DW'(ov1), '0);
      chk("rst_out_ctrl", DW'(oc1), '0);
      chk("rst_out_data", od1, '0);
      chk("rst_out_data_s0", od0, '0);
      reset = 1'b0; in_valid = 1'b0;
      step();
      chk("rst_in_ready_s1", DW'(rdy1), DW'(1));
      chk("rst_in_ready_s0", DW'(rdy0), DW'(1));
      chk("rst_idle_valid", DW'(ov1), '0);

      // Back-to-back stream, one cycle of latency, no gaps.
      for (int k = 1; k <= 8; k++) begin
         drive(1'b1, k);
         step();
         chk("stream_s1_data", od1, DW'(k));
         chk("stream_s0_data", od0, DW'(k));
         chk("stream_s1_valid", DW'(ov1), DW'(1));
         chk("stream_s0_valid", DW'(ov0), DW'(1));
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain_s1", DW'(ov1), '0);
      chk("stream_drain_s0", DW'(ov0), '0);

      // Stall with skid: 1 held, 2 absorbed, 3 refused until release.
      out_ready = 1'b0;
      drive(1'b1, 1); step();
      chk("stall_hold1", od1, DW'(1));
      chk("stall_rdy_one", DW'(rdy1), DW'(1));
      drive(1'b1, 2); step();
      chk("stall_hold1b", od1, DW'(1));
      chk("stall_rdy_two", DW'(rdy1), '0);
      drive(1'b1, 3); step();
      chk("stall_hold1c", od1, DW'(1));
      chk("stall_ctrl1", DW'(oc1), DW'(1));
      chk("stall_refuse3", DW'(rdy1), '0);
      step();
      chk("stall_hold1d", od1, DW'(1));
      out_ready = 1'b1;
      step();
      chk("release_out2", od1, DW'(2));
      chk("release_rdy", DW'(rdy1), DW'(1));
      step();
      chk("release_out3", od1, DW'(3));
      in_valid = 1'b0;
      step();
      chk("release_empty", DW'(ov1), '0);

      // Flush while full, with item 9 offered in the same cycle.
      out_ready = 1'b0;
      drive(1'b1, 10); step();
      drive(1'b1, 11); step();
      chk("pre_flush_two", DW'(rdy1), '0);
      drive(1'b1, 9); flush = 1'b1;
      step();
      chk("flush_valid", DW'(ov1), '0);
      chk("flush_ctrl", DW'(oc1), '0);
      chk("flush_rdy", DW'(rdy1), DW'(1));
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("flush_no9", DW'(ov1), '0);

      // Flush coinciding with delivery.
      drive(1'b1, 20); step();
      chk("fd_valid", DW'(ov1), DW'(1));
      chk("fd_data", od1, DW'(20));
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      chk("fd_empty", DW'(ov1), '0);
      chk("fd_count", DW'(dcnt20), DW'(1));

      // Random traffic against the queue models.
      tag = 1000;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 29) == 0);
         in_ctrl   = CW'($urandom);
         in_data   = DW'(tag);
         tag++;
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      step();
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
